// File: rtl/ps_rx_pkg.sv
// Shared definitions for the PS-stage packet receiver: packet layout, widths,
// the absorb opcode and the handshake FSM state encoding.
package ps_rx_pkg;

   localparam int PKT_W   = 62;

   localparam int CG_HI   = 61;
   localparam int CG_LO   = 51;
   localparam int PSD_HI  = 50;
   localparam int PSD_LO  = 34;
   localparam int OPC_HI  = 39;
   localparam int OPC_LO  = 34;
   localparam int CZDD_HI = 33;
   localparam int CZDD_LO = 0;

   // Opcode carried by packets the PS stage marks for absorption; the drop
   // decision itself travels on DEL_in, this value is for field decoders.
   localparam logic [OPC_HI-OPC_LO:0] OPC_ABSORB = 6'h3F;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } state_e;

   function automatic logic [CG_HI-CG_LO:0] pkt_cg(input logic [PKT_W-1:0] pkt);
      return pkt[CG_HI:CG_LO];
   endfunction

   function automatic logic [PSD_HI-PSD_LO:0] pkt_psd(input logic [PKT_W-1:0] pkt);
      return pkt[PSD_HI:PSD_LO];
   endfunction

   function automatic logic [OPC_HI-OPC_LO:0] pkt_opc(input logic [PKT_W-1:0] pkt);
      return pkt[OPC_HI:OPC_LO];
   endfunction

   function automatic logic [CZDD_HI-CZDD_LO:0] pkt_czdd(input logic [PKT_W-1:0] pkt);
      return pkt[CZDD_HI:CZDD_LO];
   endfunction

   function automatic logic pkt_is_absorb(input logic [PKT_W-1:0] pkt);
      return pkt_opc(pkt) == OPC_ABSORB;
   endfunction

endpackage

// File: rtl/ps_rx_fifo.sv
// First-word fall-through circular FIFO with synchronous active-high reset MR.
module ps_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int PKT_W = 62
) (
   input  logic                     CP,
   input  logic                     MR,
   input  logic                     push,
   input  logic [PKT_W-1:0]         push_data,
   input  logic                     pop,
   output logic [PKT_W-1:0]         head_data,
   output logic                     head_valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [PKT_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      full       = (count_q == CW'(DEPTH));
      head_valid = (count_q != '0);
      do_push    = push & ~full;
      do_pop     = pop & head_valid;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
      count      = count_q;
   end

   always_ff @(posedge CP) begin
      if (MR) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; head_data is masked to zero while empty.
   always_ff @(posedge CP) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/ps_packet_receiver.sv
// Send/Ack to valid/ready bridge for PS-stage packets: drops absorbed packets,
// queues kept ones. Define PS_RX_SYNC_EN to add a 2-flop synchroniser on Send_in.
module ps_packet_receiver #(
   parameter int DEPTH = 4,
   parameter int PKT_W = ps_rx_pkg::PKT_W,
   parameter int CNT_W = 16
) (
   input  logic                     CP,
   input  logic                     MR,
   input  logic                     Send_in,
   input  logic [PKT_W-1:0]         PACKET_IN,
   input  logic                     DEL_in,
   output logic                     Ack_out,
   output logic                     pkt_valid,
   output logic [PKT_W-1:0]         pkt_data,
   input  logic                     pkt_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]         absorb_count
);

   import ps_rx_pkg::*;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] absorb_q, absorb_d;
   logic             send_s;
   logic             fifo_push;
   logic             fifo_full;

`ifdef PS_RX_SYNC_EN
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   always_comb begin
      sync1_d = Send_in;
      sync2_d = sync1_q;
   end

   always_ff @(posedge CP) begin
      if (MR) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign send_s = sync2_q;
`else
   assign send_s = Send_in;
`endif

   // One capture per handshake: a request only counts when seen in S_IDLE.
   always_comb begin
      state_d   = state_q;
      absorb_d  = absorb_q;
      fifo_push = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (send_s) begin
               if (!DEL_in) begin
                  if (absorb_q != '1) absorb_d = absorb_q + 1'b1;
                  state_d = S_ACK;
               end else if (!fifo_full) begin
                  fifo_push = 1'b1;
                  state_d   = S_ACK;
               end
            end
         end
         S_ACK: begin
            if (!send_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CP) begin
      if (MR) begin
         state_q  <= S_IDLE;
         absorb_q <= '0;
      end else begin
         state_q  <= state_d;
         absorb_q <= absorb_d;
      end
   end

   assign Ack_out      = (state_q == S_ACK);
   assign absorb_count = absorb_q;

   ps_rx_fifo #(
      .DEPTH (DEPTH),
      .PKT_W (PKT_W)
   ) u_fifo (
      .CP         (CP),
      .MR         (MR),
      .push       (fifo_push),
      .push_data  (PACKET_IN),
      .pop        (pkt_ready),
      .head_data  (pkt_data),
      .head_valid (pkt_valid),
      .full       (fifo_full),
      .count      (fifo_count)
   );

endmodule

// File: tb/tb_ps_packet_receiver.sv
// Scoreboard bench for ps_packet_receiver: kept packets are queued when driven
// and compared as the DUT pops them.
module tb_ps_packet_receiver;

   localparam int DEPTH = 4;
   localparam int PKT_W = 62;
   localparam int CNT_W = 16;
`ifdef PS_RX_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic              CP = 1'b0;
   logic              MR;
   logic              Send_in;
   logic [PKT_W-1:0]  PACKET_IN;
   logic              DEL_in;
   logic              Ack_out;
   logic              pkt_valid;
   logic [PKT_W-1:0]  pkt_data;
   logic              pkt_ready;
   logic [2:0]        fifo_count;
   logic [CNT_W-1:0]  absorb_count;

   int n_checks = 0;
   int n_errors = 0;
   logic [PKT_W-1:0] sb [$];
   logic [PKT_W-1:0] exp_pkt;

   ps_packet_receiver #(
      .DEPTH (DEPTH),
      .PKT_W (PKT_W),
      .CNT_W (CNT_W)
   ) dut (
      .CP           (CP),
      .MR           (MR),
      .Send_in      (Send_in),
      .PACKET_IN    (PACKET_IN),
      .DEL_in       (DEL_in),
      .Ack_out      (Ack_out),
      .pkt_valid    (pkt_valid),
      .pkt_data     (pkt_data),
      .pkt_ready    (pkt_ready),
      .fifo_count   (fifo_count),
      .absorb_count (absorb_count)
   );

   always #5 CP = ~CP;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CP);
      #1;
   endtask

   task automatic wait_ack(input logic v, input string tag);
      int n = 0;
      while (Ack_out !== v && n < 20) begin
         tick();
         n++;
      end
      check(tag, 64'(Ack_out), 64'(v));
   endtask

   task automatic hs(input logic [PKT_W-1:0] p, input logic d);
      Send_in   = 1'b1;
      PACKET_IN = p;
      DEL_in    = d;
      if (d) sb.push_back(p);
      wait_ack(1'b1, "hs_ack_hi");
      Send_in = 1'b0;
      wait_ack(1'b0, "hs_ack_lo");
   endtask

   // Pop monitor: sampled mid-cycle, the pop takes effect at the next rising edge.
   always @(negedge CP) begin
      if (!MR && pkt_valid && pkt_ready) begin
         if (sb.size() == 0) begin
            check("pop_unexpected", 64'(pkt_valid), 64'd0);
         end else begin
            exp_pkt = sb.pop_front();
            check("pop_data", 64'(pkt_data), 64'(exp_pkt));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      MR = 1'b1; Send_in = 1'b0; PACKET_IN = '0; DEL_in = 1'b0; pkt_ready = 1'b0;
      tick(); tick();
      MR = 1'b0;
      check("rst_ack",    64'(Ack_out),      64'd0);
      check("rst_valid",  64'(pkt_valid),    64'd0);
      check("rst_count",  64'(fifo_count),   64'd0);
      check("rst_data",   64'(pkt_data),     64'd0);
      check("rst_absorb", 64'(absorb_count), 64'd0);

      // Single packet with exact latency
      Send_in = 1'b1; DEL_in = 1'b1; PACKET_IN = 62'h0ABC_DEF0_1234_5678;
      sb.push_back(PACKET_IN);
      repeat (1 + LAT) tick();
      check("p1_ack",   64'(Ack_out),    64'd1);
      check("p1_valid", 64'(pkt_valid),  64'd1);
      check("p1_data",  64'(pkt_data),   64'h0ABC_DEF0_1234_5678);
      check("p1_count", 64'(fifo_count), 64'd1);
      Send_in = 1'b0;
      repeat (1 + LAT) tick();
      check("p1_ack_lo", 64'(Ack_out), 64'd0);
      pkt_ready = 1'b1;
      tick();
      pkt_ready = 1'b0;
      check("p1_popped", 64'(fifo_count), 64'd0);
      check("p1_empty",  64'(pkt_valid),  64'd0);

      // Absorb three packets
      for (int i = 0; i < 3; i++) hs(62'h3FF0 + 62'(i), 1'b0);
      check("abs_count",  64'(fifo_count),   64'd0);
      check("abs_valid",  64'(pkt_valid),    64'd0);
      check("abs_absorb", 64'(absorb_count), 64'd3);

      // Back-pressure with a full FIFO
      for (int i = 1; i <= 4; i++) hs(62'(i), 1'b1);
      check("bp_full", 64'(fifo_count), 64'd4);
      Send_in = 1'b1; DEL_in = 1'b1; PACKET_IN = 62'd5;
      sb.push_back(PACKET_IN);
      repeat (3 + LAT) tick();
      check("bp_stall_ack",   64'(Ack_out),    64'd0);
      check("bp_stall_count", 64'(fifo_count), 64'd4);
      pkt_ready = 1'b1;
      tick();
      pkt_ready = 1'b0;
      check("bp_pop_ack",   64'(Ack_out),    64'd0);
      check("bp_pop_count", 64'(fifo_count), 64'd3);
      tick();
      check("bp_push_ack",   64'(Ack_out),    64'd1);
      check("bp_push_count", 64'(fifo_count), 64'd4);
      Send_in = 1'b0;
      wait_ack(1'b0, "bp_ack_lo");
      pkt_ready = 1'b1;
      repeat (4) tick();
      pkt_ready = 1'b0;
      check("bp_drained", 64'(fifo_count), 64'd0);
      check("bp_sb_empty", 64'(sb.size()), 64'd0);

      // Simultaneous push and pop at count 2
      hs(62'h11, 1'b1);
      hs(62'h12, 1'b1);
      check("sim_pre_count", 64'(fifo_count), 64'd2);
      Send_in = 1'b1; DEL_in = 1'b1; PACKET_IN = 62'h13;
      sb.push_back(PACKET_IN);
      repeat (LAT) tick();
      pkt_ready = 1'b1;
      tick();
      pkt_ready = 1'b0;
      check("sim_count", 64'(fifo_count), 64'd2);
      check("sim_ack",   64'(Ack_out),    64'd1);
      check("sim_head",  64'(pkt_data),   64'h12);
      Send_in = 1'b0;
      wait_ack(1'b0, "sim_ack_lo");
      pkt_ready = 1'b1;
      repeat (2) tick();
      pkt_ready = 1'b0;
      check("sim_drained", 64'(fifo_count), 64'd0);

      // Reset in S_ACK with two entries queued; held Send_in is a new request
      hs(62'h21, 1'b1);
      Send_in = 1'b1; DEL_in = 1'b1; PACKET_IN = 62'h22;
      sb.push_back(PACKET_IN);
      wait_ack(1'b1, "mr_pre_ack");
      check("mr_pre_count", 64'(fifo_count), 64'd2);
      MR = 1'b1;
      PACKET_IN = 62'h24;
      tick();
      MR = 1'b0;
      sb.delete();
      check("mr_ack",    64'(Ack_out),      64'd0);
      check("mr_count",  64'(fifo_count),   64'd0);
      check("mr_absorb", 64'(absorb_count), 64'd0);
      check("mr_valid",  64'(pkt_valid),    64'd0);
      sb.push_back(PACKET_IN);
      repeat (1 + LAT) tick();
      check("mr_new_ack",   64'(Ack_out),    64'd1);
      check("mr_new_count", 64'(fifo_count), 64'd1);
      check("mr_new_data",  64'(pkt_data),   64'h24);
      Send_in = 1'b0;
      wait_ack(1'b0, "mr_new_ack_lo");
      pkt_ready = 1'b1;
      tick();
      pkt_ready = 1'b0;
      check("end_count",    64'(fifo_count), 64'd0);
      check("end_sb_empty", 64'(sb.size()),  64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ps_packet_receiver.md
Name: ps_packet_receiver

Overview:
- Clocked receiving end of the PS stage output interface.
- Accepts 62-bit merged packets (CG | PS data | CZDD) over the 4-phase Send/Ack bundled-data handshake.
- Drops packets flagged for absorption (DEL_in low), buffers the rest in a small FIFO, and presents them to the next pipeline stage on a valid/ready port.
- Sits between the PS stage and the function/operation stage; it is the bridge from the self-timed Send/Ack domain into the clocked domain.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- PKT_W, 62, packet width.
- CNT_W, 16, absorbed-packet counter width.

Ports:
- CP  input  1  clock
- MR  input  1  reset; synchronous, active-high
- Send_in  input  1  request from PS stage; level, 4-phase
- PACKET_IN  input  PKT_W  packet; stable while Send_in high
- DEL_in  input  1  0 = absorb (drop), 1 = keep; qualified by Send_in
- Ack_out  output  1  acknowledge to PS stage
- pkt_valid  output  1  FIFO head valid
- pkt_data  output  PKT_W  FIFO head; first-word fall-through
- pkt_ready  input  1  downstream accepts head
- fifo_count  output  clog2(DEPTH)+1  occupancy
- absorb_count  output  CNT_W  number of packets dropped

Behaviour:
- Reset (MR high at a CP edge):
  - state = S_IDLE; Ack_out = 0.
  - FIFO empty: pkt_valid = 0, fifo_count = 0, pkt_data = 0.
  - absorb_count = 0.
  - MR overrides every other event in the same cycle.
  - A Send_in held high across reset is treated as a new request. MR is shared with the sender, so both ends restart together.
- send_s is the qualified request: Send_in itself, or its synchronised version (see Optional Feature).
- FSM, state S_IDLE (Ack_out = 0):
  - send_s = 1 and DEL_in = 0: absorb_count increments (saturates at all-ones); go to S_ACK. No FIFO space is needed.
  - send_s = 1, DEL_in = 1, FIFO not full: push PACKET_IN; go to S_ACK.
  - send_s = 1, DEL_in = 1, FIFO full: stay in S_IDLE with Ack_out held 0. This stall is the back-pressure to the sender.
- FSM, state S_ACK (Ack_out = 1): when send_s = 0, go to S_IDLE and Ack_out falls. Ack_out is a registered state decode.
- Exactly one push or drop per handshake. A Send_in that stays high in S_ACK is never re-captured.
- Latency, no-sync build:
  - Send_in sampled high at edge N gives Ack_out = 1 and the push after edge N.
  - pkt_valid = 1 after edge N when the FIFO was empty.
  - Send_in low sampled at edge M gives Ack_out = 0 after edge M.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH.
  - Full is fifo_count == DEPTH; empty is fifo_count == 0.
  - Pop happens when pkt_valid & pkt_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full decision uses the registered count. A pop in the same cycle does not allow a push; the push waits one cycle.
  - pkt_data is the head entry; it must not change while pkt_valid = 1 and pkt_ready = 0.
- DEL_in and PACKET_IN are only sampled in S_IDLE when send_s = 1; they are don't-care otherwise.

Optional Feature:
- Macro: PS_RX_SYNC_EN.
- Defined:
  - Send_in passes through a 2-flop synchroniser, reset to 0 by MR; send_s is the second flop.
  - PACKET_IN and DEL_in are captured on the cycle send_s is first seen high; the bundled-data constraint guarantees they are settled.
  - All Send-related latencies grow by 2 cycles.
- Undefined: send_s = Send_in directly, for a sender in the same CP domain.

Decomposition:
- Shared package/header holds:
  - packet field ranges: CG 61:51, PS data 50:34, OPC 39:34, CZDD 33:0;
  - PKT_W;
  - the ABSORB opcode constant;
  - FSM state encodings S_IDLE / S_ACK.
- One sub-module, ps_rx_fifo: a parameterised FIFO (DEPTH, PKT_W) with push/pop/count and synchronous MR.
- The top level holds the FSM, optional synchroniser and counter.

Test Plan:
- Single packet, no sync: MR, then Send_in = 1, DEL_in = 1, PACKET_IN = 62'h0ABC_DEF0_1234_5678 → Ack_out = 1 one edge later; pkt_valid = 1 with that pkt_data; after Send_in = 0, Ack_out = 0 next edge; pop with pkt_ready → fifo_count = 0.
- Absorb: 3 handshakes with DEL_in = 0 → 3 Acks; fifo_count = 0; pkt_valid stays 0; absorb_count = 3.
- Back-pressure, DEPTH = 4, pkt_ready = 0: 5 keep-packets 1..5 → first 4 acked; 5th holds Ack_out = 0. Pulse pkt_ready one cycle → head 1 popped; 5th acked next cycle. Drain order 2,3,4,5.
- Simultaneous push/pop with count = 2 and pkt_ready = 1 during a push → fifo_count stays 2; order preserved.
- Reset mid-handshake: MR in S_ACK with 2 entries queued → Ack_out = 0, fifo_count = 0, absorb_count = 0 next edge. Send_in held high is then captured as a new packet.
- With PS_RX_SYNC_EN defined: Send_in rises at edge N → Ack_out = 1 after edge N+2; the handshake still completes once.
